// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forward selects, shadow slots.
package pipe_ctrl_pkg;

    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] rd;
        logic                 is_load;
    } shadow_slot_t;

    // x0 is hardwired zero, so it never matches a producer.
    function automatic logic rs_hit(input logic use_rs, input logic [RF_ADDR_W-1:0] rs,
                                    input shadow_slot_t slot);
        return use_rs && (rs != '0) && slot.valid && (slot.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shadow EX/MEM/WB destination tracker: load-use detect (comb) and registered forward selects.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_id_valid,
    input  logic [RF_ADDR_W-1:0] i_id_rs1,
    input  logic [RF_ADDR_W-1:0] i_id_rs2,
    input  logic                 i_id_use_rs1,
    input  logic                 i_id_use_rs2,
    input  logic [RF_ADDR_W-1:0] i_id_rd,
    input  logic                 i_id_wen,
    input  logic                 i_id_is_load,
    input  logic                 i_idex_flush,
    output logic                 o_load_use,
    output logic [1:0]           o_fwd_rs1_sel,
    output logic [1:0]           o_fwd_rs2_sel
);

    shadow_slot_t r_ex, r_mem, r_wb;
    shadow_slot_t w_id_entry;
    fwd_sel_e     r_fwd_rs1_sel, r_fwd_rs2_sel;
    fwd_sel_e     w_fwd_rs1_sel, w_fwd_rs2_sel;
    logic         w_use_rs1, w_use_rs2;
    logic         w_unused_wb;

    // Current EX producer lands in EX/MEM next cycle, current MEM producer in MEM/WB.
    function automatic fwd_sel_e pick_src(input logic use_rs, input logic [RF_ADDR_W-1:0] rs,
                                          input shadow_slot_t ex, input shadow_slot_t mem);
        if (rs_hit(use_rs, rs, ex))
            return FWD_EXMEM;
        else if (rs_hit(use_rs, rs, mem))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    assign w_use_rs1 = i_id_valid & i_id_use_rs1;
    assign w_use_rs2 = i_id_valid & i_id_use_rs2;

    assign w_id_entry.valid   = i_id_valid & i_id_wen & (i_id_rd != '0);
    assign w_id_entry.rd      = i_id_rd;
    assign w_id_entry.is_load = i_id_is_load;

    assign o_load_use = r_ex.is_load &
                        (rs_hit(w_use_rs1, i_id_rs1, r_ex) | rs_hit(w_use_rs2, i_id_rs2, r_ex));

    assign w_fwd_rs1_sel = pick_src(w_use_rs1, i_id_rs1, r_ex, r_mem);
    assign w_fwd_rs2_sel = pick_src(w_use_rs2, i_id_rs2, r_ex, r_mem);

    // WB slot is kept for debug visibility only; WB->ID reads use regfile write-through.
    assign w_unused_wb = ^r_wb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_fwd_rs1_sel <= FWD_RF;
            r_fwd_rs2_sel <= FWD_RF;
        end else begin
            r_wb          <= r_mem;
            r_mem         <= r_ex;
            r_ex          <= i_idex_flush ? shadow_slot_t'('0) : w_id_entry;
            r_fwd_rs1_sel <= i_idex_flush ? FWD_RF : w_fwd_rs1_sel;
            r_fwd_rs2_sel <= i_idex_flush ? FWD_RF : w_fwd_rs2_sel;
        end
    end

    assign o_fwd_rs1_sel = r_fwd_rs1_sel;
    assign o_fwd_rs2_sel = r_fwd_rs2_sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: owns fetch PC, FILL/RUN/TRAP FSM, stall/flush generation and misaligned-target trap.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          REG_ADDR_WIDTH = RF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_use_rs1,
    input  logic                      i_id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_wen,
    input  logic                      i_id_is_load,
    input  logic                      i_ex_redirect,
    input  logic [63:0]               i_ex_target,
    input  logic [63:0]               i_ex_pc,
    output logic [63:0]               o_pc,
    output logic                      o_ifid_stall,
    output logic                      o_ifid_flush,
    output logic                      o_idex_flush,
    output logic [1:0]                o_fwd_rs1_sel,
    output logic [1:0]                o_fwd_rs2_sel,
    output logic                      o_exc_valid,
    output logic [3:0]                o_exc_cause,
    output logic [63:0]               o_exc_epc,
    output logic                      o_halted
);

    ctrl_state_e r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic        r_exc_valid;
    logic [3:0]  r_exc_cause;
    logic [63:0] r_exc_epc;
    logic        w_load_use, w_misalign, w_trap_take;

    pipe_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_id_valid    (i_id_valid),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_use_rs1  (i_id_use_rs1),
        .i_id_use_rs2  (i_id_use_rs2),
        .i_id_rd       (i_id_rd),
        .i_id_wen      (i_id_wen),
        .i_id_is_load  (i_id_is_load),
        .i_idex_flush  (o_idex_flush),
        .o_load_use    (w_load_use),
        .o_fwd_rs1_sel (o_fwd_rs1_sel),
        .o_fwd_rs2_sel (o_fwd_rs2_sel)
    );

    assign w_misalign = i_ex_redirect & (i_ex_target[1:0] != 2'b00);

    always_comb begin
        o_ifid_stall = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        w_trap_take  = 1'b0;
        w_pc_nxt     = r_pc;
        w_state_nxt  = r_state;
        case (r_state)
            // First imem read is still in flight; whatever sits in IF/ID is stale.
            FILL: begin
                o_ifid_flush = 1'b1;
                w_pc_nxt     = r_pc + 64'd4;
                w_state_nxt  = RUN;
            end
            RUN: begin
                if (i_ex_redirect) begin
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                    if (w_misalign) begin
                        w_trap_take = 1'b1;
                        w_state_nxt = TRAP;
                    end else begin
                        w_pc_nxt = i_ex_target;
                    end
                end else if (w_load_use) begin
                    o_ifid_stall = 1'b1;
                    o_idex_flush = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + 64'd4;
                end
            end
            TRAP: begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_pc        <= RESET_PC;
            r_exc_valid <= 1'b0;
            r_exc_cause <= 4'd0;
            r_exc_epc   <= 64'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_exc_valid <= w_trap_take;
            if (w_trap_take) begin
                r_exc_cause <= EXC_INSTR_MISALIGNED;
                r_exc_epc   <= i_ex_pc;
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_exc_valid = r_exc_valid;
    assign o_exc_cause = r_exc_cause;
    assign o_exc_epc   = r_exc_epc;
    assign o_halted    = (r_state == TRAP);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_use_rs1, id_use_rs2, id_wen, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        ex_redirect;
    logic [63:0] ex_target, ex_pc;
    logic [63:0] pc, exc_epc;
    logic        ifid_stall, ifid_flush, idex_flush, exc_valid, halted;
    logic [1:0]  fwd1, fwd2;
    logic [3:0]  exc_cause;

    int total = 0;
    int bad   = 0;

    // Behavioural model: index 0 = instruction in EX, 1 = MEM, 2 = WB.
    logic [63:0] m_pc, m_epc;
    bit          m_fill, m_halt, m_exc;
    logic [1:0]  m_s1, m_s2;
    bit          sv[3];
    logic [4:0]  srd[3];
    bit          sld[3];

    pipe_hazard_ctrl #(.RESET_PC(64'h0), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
        .i_id_rd(id_rd), .i_id_wen(id_wen), .i_id_is_load(id_is_load),
        .i_ex_redirect(ex_redirect), .i_ex_target(ex_target), .i_ex_pc(ex_pc),
        .o_pc(pc), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
        .o_idex_flush(idex_flush), .o_fwd_rs1_sel(fwd1), .o_fwd_rs2_sel(fwd2),
        .o_exc_valid(exc_valid), .o_exc_cause(exc_cause), .o_exc_epc(exc_epc),
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input bit u, input logic [4:0] rs, input int k);
        return u && rs != 5'd0 && sv[k] && srd[k] == rs;
    endfunction

    task automatic model_reset();
        m_pc = 64'h0; m_epc = 64'h0;
        m_fill = 1'b1; m_halt = 1'b0; m_exc = 1'b0;
        m_s1 = 2'b00; m_s2 = 2'b00;
        for (int k = 0; k < 3; k++) begin
            sv[k] = 1'b0; srd[k] = 5'd0; sld[k] = 1'b0;
        end
    endtask

    task automatic set_id(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                          input bit u2, input logic [4:0] rd, input bit wen, input bit ld);
        id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
        id_rd = rd; id_wen = wen; id_is_load = ld;
    endtask

    // Checks every output at the negedge, then advances the model across the next posedge.
    task automatic cycle();
        bit          lu, e_st, e_f1, e_f2, mis, take;
        logic [63:0] npc;
        logic [1:0]  n1, n2;
        logic [1:0]  tlo;
        @(negedge clk);
        lu = id_valid && sv[0] && sld[0] &&
             (hit(id_use_rs1, id_rs1, 0) || hit(id_use_rs2, id_rs2, 0));
        e_st = 0; e_f1 = 0; e_f2 = 0;
        if (m_halt) begin e_f1 = 1; e_f2 = 1; end
        else if (m_fill) e_f1 = 1;
        else if (ex_redirect) begin e_f1 = 1; e_f2 = 1; end
        else if (lu) begin e_st = 1; e_f2 = 1; end
        chk("pc", pc, m_pc);
        chk("ifid_stall", ifid_stall, e_st);
        chk("ifid_flush", ifid_flush, e_f1);
        chk("idex_flush", idex_flush, e_f2);
        chk("fwd_rs1_sel", fwd1, m_s1);
        chk("fwd_rs2_sel", fwd2, m_s2);
        chk("exc_valid", exc_valid, m_exc);
        chk("exc_cause", exc_cause, 4'd0);
        chk("exc_epc", exc_epc, m_epc);
        chk("halted", halted, m_halt);

        tlo  = ex_target[1:0];
        mis  = ex_redirect && tlo != 2'b00;
        take = !m_halt && !m_fill && mis;
        if (m_halt) npc = m_pc;
        else if (m_fill) npc = m_pc + 64'd4;
        else if (ex_redirect) npc = mis ? m_pc : ex_target;
        else if (lu) npc = m_pc;
        else npc = m_pc + 64'd4;
        n1 = 2'b00; n2 = 2'b00;
        if (!e_f2) begin
            if (hit(id_valid && id_use_rs1, id_rs1, 0)) n1 = 2'b01;
            else if (hit(id_valid && id_use_rs1, id_rs1, 1)) n1 = 2'b10;
            if (hit(id_valid && id_use_rs2, id_rs2, 0)) n2 = 2'b01;
            else if (hit(id_valid && id_use_rs2, id_rs2, 1)) n2 = 2'b10;
        end

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            sv[2] = sv[1]; srd[2] = srd[1]; sld[2] = sld[1];
            sv[1] = sv[0]; srd[1] = srd[0]; sld[1] = sld[0];
            sv[0] = !e_f2 && id_valid && id_wen && id_rd != 5'd0;
            srd[0] = id_rd; sld[0] = id_is_load;
            m_s1 = n1; m_s2 = n2; m_pc = npc;
            m_exc = take;
            if (take) m_epc = ex_pc;
            m_halt = m_halt || take;
            m_fill = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] held;
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_redirect = 1'b0; ex_target = 64'h0; ex_pc = 64'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        chk("rst_pc", pc, 64'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_exc_valid", exc_valid, 1'b0);
        chk("rst_fwd1", fwd1, 2'b00);
        rst = 1'b0;

        // Fill then straight-line fetch: PC 0,4,8,C.
        for (int i = 0; i < 4; i++) cycle();
        chk("pc_after_4", pc, 64'h10);

        // Producer x5 then two consumers.
        set_id(1, 0, 0, 0, 0, 5, 1, 0); cycle();
        set_id(1, 5, 1, 0, 0, 0, 0, 0); cycle();
        chk("fwd1_exmem", fwd1, 2'b01);
        cycle();
        chk("fwd1_memwb", fwd1, 2'b10);

        // Load x7 followed by a user of x7: one stall cycle.
        set_id(1, 0, 0, 0, 0, 7, 1, 1); cycle();
        held = pc;
        set_id(1, 0, 0, 7, 1, 0, 0, 0); cycle();
        chk("loaduse_pc_held", pc, held);
        chk("loaduse_fwd2_bubble", fwd2, 2'b00);
        cycle();
        chk("after_stall_fwd2", fwd2, 2'b10);

        // Redirect overrides a load-use stall.
        set_id(1, 0, 0, 0, 0, 7, 1, 1); cycle();
        set_id(1, 0, 0, 7, 1, 0, 0, 0);
        ex_redirect = 1'b1; ex_target = 64'h100;
        cycle();
        ex_redirect = 1'b0;
        chk("redirect_pc", pc, 64'h100);

        // x0 as load destination and as source.
        set_id(1, 0, 0, 0, 0, 0, 1, 1); cycle();
        set_id(1, 0, 1, 0, 1, 0, 0, 0); cycle();
        chk("x0_fwd1", fwd1, 2'b00);
        chk("x0_fwd2", fwd2, 2'b00);

        // Randomized traffic, including misaligned traps and resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 9) < 3);
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
            ex_redirect = $urandom_range(0, 9) == 0;
            ex_target = {$urandom, $urandom};
            if ($urandom_range(0, 9) != 0) ex_target[1:0] = 2'b00;
            ex_pc = {$urandom, $urandom};
            cycle();
        end
        rst = 1'b0; ex_redirect = 1'b0;

        rst = 1'b1; cycle(); rst = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();

        // Misaligned redirect traps and halts.
        held = pc;
        ex_redirect = 1'b1; ex_target = 64'h102; ex_pc = 64'h40;
        cycle();
        chk("trap_exc_valid", exc_valid, 1'b1);
        chk("trap_cause", exc_cause, 4'd0);
        chk("trap_epc", exc_epc, 64'h40);
        chk("trap_halted", halted, 1'b1);
        chk("trap_pc_frozen", pc, held);
        ex_target = 64'h200;
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        cycle();
        chk("trap_pulse_end", exc_valid, 1'b0);
        chk("trap_pc_still", pc, held);
        ex_redirect = 1'b0;
        cycle();

        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_in_trap_pc", pc, 64'h0);
        chk("rst_in_trap_halted", halted, 1'b0);
        chk("rst_in_trap_exc", exc_valid, 1'b0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
